mem_access_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the EX/MEM register; consumes its ALU result, store data, destination register and control bits.
- Runs word loads/stores against a variable-latency data memory over a req/ack handshake and stalls the upstream pipeline while an access is in flight.
- Selects write-back data, registers results into the MEM/WB boundary, and flags misaligned-access and bus-timeout exceptions.

---
 rtl/mem_access_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: runs word loads/stores against a variable-latency data
// memory over a req/ack handshake. It stalls upstream while an access is in
// flight, selects the write-back value, and registers results into MEM/WB.
// It also flags misaligned accesses and bus timeouts as one-cycle exception pulses.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_write_data,
  input  logic [4:0]  in_write_reg,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_mem_to_reg,
  input  logic        in_reg_write,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_write_reg,
  output logic        wb_reg_write,
  output logic [31:0] wb_pc,
  output logic        mem_exc,
  output logic [1:0]  mem_exc_code
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_LD_MIS  = 2'b01;
  localparam logic [1:0] EXC_ST_MIS  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           tmo_q, tmo_d;
  logic [31:0]    wb_data_q, wb_data_d;
  logic [4:0]     wb_rd_q, wb_rd_d;
  logic           wb_rw_q, wb_rw_d;
  logic [31:0]    wb_pc_q, wb_pc_d;
  logic           exc_q, exc_d;
  logic [1:0]     exc_code_q, exc_code_d;

  logic           mem_op;
  logic           aligned;
  logic [31:0]    sel_data;

  assign mem_op  = in_mem_read | in_mem_write;
  assign aligned = (in_alu_out[1:0] == 2'b00);

  // Write-back source select; 01 uses the data captured from the last ack.
  always_comb begin
    sel_data = in_alu_out;
    case (in_mem_to_reg)
      2'b01:   sel_data = rdata_q;
      2'b10:   sel_data = in_pc;
      default: sel_data = in_alu_out;
    endcase
  end

  // State and datapath registers; reset also abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tmo_q      <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_pc_q    <= '0;
      exc_q      <= 1'b0;
      exc_code_q <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tmo_q      <= tmo_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_pc_q    <= wb_pc_d;
      exc_q      <= exc_d;
      exc_code_q <= exc_code_d;
    end
  end

  // Next-state logic; an ack on the limit cycle takes priority over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op && aligned) state_d = ST_WAIT;
      ST_WAIT: if (dmem_ack || (cnt_q == CNT_LIMIT)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; MEM/WB sees a bubble unless explicitly loaded.
  always_comb begin
    mem_stall  = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && mem_op && aligned);
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tmo_d      = tmo_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_pc_d    = wb_pc_q;
    wb_rw_d    = 1'b0;
    exc_d      = 1'b0;
    exc_code_d = EXC_NONE;
    case (state_q)
      ST_IDLE: begin
        if (!mem_op) begin
          wb_data_d = sel_data;
          wb_rd_d   = in_write_reg;
          wb_pc_d   = in_pc;
          wb_rw_d   = in_reg_write;
        end else if (!aligned) begin
          wb_data_d  = sel_data;
          wb_rd_d    = in_write_reg;
          wb_pc_d    = in_pc;
          exc_d      = 1'b1;
          exc_code_d = in_mem_read ? EXC_LD_MIS : EXC_ST_MIS;
        end else begin
          // Read wins when both read and write are asserted.
          addr_d  = in_alu_out;
          wdata_d = in_write_data;
          we_d    = in_mem_write & ~in_mem_read;
          req_d   = 1'b1;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          req_d   = 1'b0;
        end else if (cnt_q == CNT_LIMIT) begin
          req_d = 1'b0;
          tmo_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        wb_data_d  = sel_data;
        wb_rd_d    = in_write_reg;
        wb_pc_d    = in_pc;
        wb_rw_d    = in_reg_write & ~tmo_q;
        exc_d      = tmo_q;
        exc_code_d = tmo_q ? EXC_TIMEOUT : EXC_NONE;
        tmo_d      = 1'b0;
      end
      default: ;
    endcase
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_data      = wb_data_q;
  assign wb_write_reg = wb_rd_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_pc        = wb_pc_q;
  assign mem_exc      = exc_q;
  assign mem_exc_code = exc_code_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed steps followed by randomized
// instructions. A transaction-level model predicts stall length, write-back
// values and exceptions. A bench-side memory answers the req/ack handshake.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_pc, in_alu_out, in_write_data;
  logic [4:0]  in_write_reg;
  logic        in_mem_read, in_mem_write, in_reg_write;
  logic [1:0]  in_mem_to_reg;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] wb_data, wb_pc;
  logic [4:0]  wb_write_reg;
  logic        wb_reg_write, mem_exc;
  logic [1:0]  mem_exc_code;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_model [logic [29:0]];

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_pc(in_pc), .in_alu_out(in_alu_out), .in_write_data(in_write_data),
    .in_write_reg(in_write_reg), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .in_reg_write(in_reg_write), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_data(wb_data), .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
    .wb_pc(wb_pc), .mem_exc(mem_exc), .mem_exc_code(mem_exc_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // One instruction through the stage. ack_delay = index of the WAIT cycle
  // in which ack is given (0 = first), or -1 for no ack at all.
  task automatic run_op(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [1:0] sel, input logic rw, input int ack_delay);
    logic        mop, is_load, algn, got_ack, exp_rw, exp_exc, exp_we;
    logic [1:0]  exp_code;
    logic [31:0] ack_data;
    int          exp_stalls, stalls, waits;
    mop     = rd_en | wr_en;
    is_load = rd_en;
    algn    = (addr[1:0] == 2'b00);
    exp_we  = wr_en & ~rd_en;
    if (mop && algn) exp_stalls = (ack_delay < 0) ? 1 + TMO : 2 + ack_delay;
    else             exp_stalls = 0;

    @(negedge clk);
    in_mem_read = rd_en; in_mem_write = wr_en; in_alu_out = addr;
    in_write_data = wdata; in_pc = pc; in_write_reg = rd;
    in_mem_to_reg = sel; in_reg_write = rw; dmem_ack = 1'b0;
    stalls = 0; waits = 0; got_ack = 1'b0; ack_data = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (!mem_stall) break;
      check("req_level", dmem_req, stalls > 0);
      if (dmem_req) begin
        check("dmem_addr", dmem_addr, addr);
        check("dmem_wdata", dmem_wdata, wdata);
        check("dmem_we", dmem_we, exp_we);
        check("bubble_rw", wb_reg_write, 1'b0);
        check("bubble_exc", mem_exc, 1'b0);
        if (waits == ack_delay) begin
          ack_data = is_load ? mem_rd(addr) : $urandom;
          if (!is_load) mem_model[addr[31:2]] = wdata;
          dmem_rdata = ack_data;
          dmem_ack   = 1'b1;
          got_ack    = 1'b1;
        end
        waits++;
      end
      stalls++;
      @(negedge clk);
      dmem_ack = 1'b0;
    end

    if (!mop)           begin exp_rw = rw;   exp_exc = 1'b0; exp_code = 2'b00; end
    else if (!algn)     begin exp_rw = 1'b0; exp_exc = 1'b1; exp_code = is_load ? 2'b01 : 2'b10; end
    else if (!got_ack)  begin exp_rw = 1'b0; exp_exc = 1'b1; exp_code = 2'b11; end
    else                begin exp_rw = rw;   exp_exc = 1'b0; exp_code = 2'b00; end

    @(posedge clk);
    #1;
    check("stall_cycles", stalls, exp_stalls);
    check("wb_write_reg", wb_write_reg, rd);
    check("wb_pc", wb_pc, pc);
    check("wb_reg_write", wb_reg_write, exp_rw);
    check("mem_exc", mem_exc, exp_exc);
    check("mem_exc_code", mem_exc_code, exp_code);
    check("req_after", dmem_req, 1'b0);
    if (sel == 2'b10)                 check("wb_data_pc", wb_data, pc);
    else if (sel != 2'b01)            check("wb_data_alu", wb_data, addr);
    else if (got_ack)                 check("wb_data_mem", wb_data, ack_data);
    $display("op rd=%0b wr=%0b addr=%h sel=%0d delay=%0d stalls=%0d wb_data=%h exc=%0b code=%0d",
             rd_en, wr_en, addr, sel, ack_delay, stalls, wb_data, mem_exc, mem_exc_code);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    int          kind, dl;

    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    in_pc = '0; in_alu_out = '0; in_write_data = '0; in_write_reg = '0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_mem_to_reg = '0; in_reg_write = 1'b0;
    #2;
    check("rst_req", dmem_req, 1'b0);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_rw", wb_reg_write, 1'b0);
    check("rst_exc", {mem_exc, mem_exc_code}, 3'b000);
    check("rst_addr", dmem_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed steps
    run_op(0, 0, 32'h0000_1234, 32'h0, 32'h0000_0040, 5'd5, 2'b00, 1, -1);
    run_op(1, 0, 32'h0000_0100, 32'h0, 32'h0000_0044, 5'd6, 2'b01, 1, 1);
    mem_model[30'h0000_0200 >> 2] = 32'h0;
    run_op(0, 1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0000_0048, 5'd0, 2'b00, 0, 0);
    run_op(1, 0, 32'h0000_0200, 32'h0, 32'h0000_004C, 5'd7, 2'b01, 1, 0);
    run_op(1, 0, 32'h0000_0103, 32'h0, 32'h0000_0050, 5'd8, 2'b01, 1, 0);
    run_op(0, 1, 32'h0000_0202, 32'h1, 32'h0000_0054, 5'd9, 2'b00, 0, 0);
    run_op(0, 0, 32'h0000_0777, 32'h0, 32'h0000_0058, 5'd10, 2'b10, 1, -1);
    run_op(1, 0, 32'h0000_0300, 32'h0, 32'h0000_005C, 5'd11, 2'b01, 1, -1);
    run_op(1, 0, 32'h0000_0304, 32'h0, 32'h0000_0060, 5'd12, 2'b01, 1, TMO - 1);

    // Stray ack after a timeout must not disturb an idle ALU op
    run_op(1, 0, 32'h0000_0308, 32'h0, 32'h0000_0064, 5'd13, 2'b00, 1, -1);
    @(negedge clk);
    in_mem_read = 0; in_mem_write = 0; in_alu_out = 32'h55; in_pc = 32'h68;
    in_write_reg = 5'd14; in_mem_to_reg = 2'b00; in_reg_write = 1;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    #1;
    check("stray_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    check("stray_req", dmem_req, 1'b0);
    check("stray_wb", wb_data, 32'h55);
    check("stray_exc", mem_exc, 1'b0);
    @(negedge clk); dmem_ack = 1'b0;
    $display("stray ack step wb_data=%h req=%0b", wb_data, dmem_req);

    // Reset during WAIT
    @(negedge clk);
    in_mem_read = 1; in_alu_out = 32'h400; in_write_reg = 5'd15; in_reg_write = 1;
    @(negedge clk); #1;
    check("wait_req", dmem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_req", dmem_req, 1'b0);
    check("rst_mid_wb", {wb_data, wb_pc}, 64'h0);
    check("rst_mid_rd", {wb_write_reg, wb_reg_write, mem_exc, mem_exc_code}, 9'h0);
    $display("reset during wait req=%0b wb_data=%h", dmem_req, wb_data);
    @(negedge clk);
    reset = 1'b0; in_mem_read = 0;
    run_op(0, 0, 32'h0000_1234, 32'h0, 32'h0000_0070, 5'd5, 2'b00, 1, -1);

    // Randomized instructions
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom & 32'h0000_0FFC;
      dl   = $urandom_range(0, 5);
      if (dl >= TMO) dl = -1;
      s    = 2'($urandom_range(0, 3));
      case (kind)
        0: begin
          if (s == 2'b01) s = 2'b11;
          run_op(0, 0, $urandom, $urandom, $urandom, 5'($urandom), s, 1'($urandom), dl);
        end
        1: run_op(1, ($urandom_range(0, 7) == 0), a, $urandom, $urandom, 5'($urandom), s, 1'($urandom), dl);
        2: run_op(0, 1, a, $urandom, $urandom, 5'($urandom), s, 1'($urandom), dl);
        default: begin
          if (s == 2'b01) s = 2'b00;
          run_op(1'($urandom), 1'b1, a | 32'($urandom_range(1, 3)), $urandom, $urandom,
                 5'($urandom), s, 1'($urandom), dl);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
